// File: rtl/bw_mac_accumulator.sv
// rtl/bw_mac_accumulator.sv - saturating signed dot-product accumulator for Baugh-Wooley products
module bw_mac_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 10,
  parameter int NUM_TERMS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_sat,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // a single-term configuration still needs a one-bit counter
  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               out_sat_q, out_sat_d;

  logic [ACC_W:0]     sum_ext;
  logic               sum_ovf;
  logic [ACC_W-1:0]   sum_clamped;

  // one guard bit above the accumulator; disagreement with the sign bit means overflow
  always_comb begin
    sum_ext     = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    sum_ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum_clamped = sum_ext[ACC_W-1:0];
    if (sum_ovf) begin
      sum_clamped = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // next-state and datapath update; clear overrides every other request
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sat_d     = sat_q;
    out_acc_d = out_acc_q;
    out_sat_d = out_sat_q;
    if (clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc_d   = sum_clamped;
            sat_d   = sat_q | sum_ovf;
            count_d = count_q + 1'b1;
            if (count_q == LAST_CNT) begin
              state_d   = S_DONE;
              count_d   = '0;
              out_acc_d = sum_clamped;
              out_sat_d = sat_q | sum_ovf;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (start) begin
              state_d = S_ACCUM;
              acc_d   = '0;
              count_d = '0;
              sat_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      out_acc_q <= out_acc_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;

endmodule
